// File: rtl/dnn_pkg.sv
// Shared helpers for the DNN datapath blocks.
package dnn_pkg;

    // clog2 with a floor of 1 so that single-entry memories still get a 1-bit address.
    function automatic int clog2_floor1(input int n);
        int result;
        result = 0;
        while ((1 << result) < n) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/simple_dual_port_mem.sv
// One bank: write-only port A, registered read-first port B, pattern or zero initial contents.
module simple_dual_port_mem
    import dnn_pkg::*;
#(
    parameter int purpose = 1,
    parameter int depth   = 16,
    parameter int width   = 12,
    parameter int index   = 0,
    localparam int addrsize = clog2_floor1(depth)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we_i,
    input  logic [addrsize-1:0] addr_wr_i,
    input  logic [width-1:0]    data_wr_i,
    input  logic [addrsize-1:0] addr_rd_i,
    output logic [width-1:0]    data_rd_o
);

    typedef logic [width-1:0] mem_t [depth];

    // Inverted global word index gives every word of every bank a distinct start value.
    function automatic mem_t init_contents();
        mem_t m;
        for (int a = 0; a < depth; a++) begin
            if (purpose == 0) begin
                m[a] = '0;
            end else begin
                m[a] = width'(~(index * depth + a));
            end
        end
        return m;
    endfunction

    localparam logic [addrsize:0] DEPTH_LIMIT = depth[addrsize:0];

    // No reset on the array so it maps onto block RAM.
    logic [width-1:0] mem_q [depth] = init_contents();
    logic [width-1:0] data_rd_q;
    logic [width-1:0] data_rd_d;
    logic             wr_valid;
    logic             rd_valid;

    assign wr_valid = ({1'b0, addr_wr_i} < DEPTH_LIMIT);
    assign rd_valid = ({1'b0, addr_rd_i} < DEPTH_LIMIT);

    always_ff @(posedge clk) begin
        if (reset && we_i && wr_valid) begin
            mem_q[addr_wr_i] <= data_wr_i;
        end
    end

    // The nonblocking write above makes this read see the old word on a collision.
    always_comb begin
        data_rd_d = '0;
        if (rd_valid) begin
            data_rd_d = mem_q[addr_rd_i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_rd_q <= '0;
        end else begin
            data_rd_q <= data_rd_d;
        end
    end

    assign data_rd_o = data_rd_q;

endmodule

// File: rtl/parallel_simple_dual_port_memory.sv
// z independent simple dual-port banks; bank i uses slice i of every flattened bus.
module parallel_simple_dual_port_memory
    import dnn_pkg::*;
#(
    parameter int purpose = 1,
    parameter int z       = 2,
    parameter int depth   = 16,
    parameter int width   = 12,
    localparam int addrsize = clog2_floor1(depth)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [z*addrsize-1:0] addressA,
    input  logic [z-1:0]          weA,
    input  logic [z*width-1:0]    data_inA,
    input  logic [z*addrsize-1:0] addressB,
    output logic [z*width-1:0]    data_outB
);

    for (genvar gi = 0; gi < z; gi++) begin : g_bank
        simple_dual_port_mem #(
            .purpose(purpose),
            .depth  (depth),
            .width  (width),
            .index  (gi)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .we_i     (weA[gi]),
            .addr_wr_i(addressA[gi*addrsize +: addrsize]),
            .data_wr_i(data_inA[gi*width +: width]),
            .addr_rd_i(addressB[gi*addrsize +: addrsize]),
            .data_rd_o(data_outB[gi*width +: width])
        );
    end

endmodule

// File: tb/tb_parallel_simple_dual_port_memory.sv
// Directed test of the two-bank, 16x12 configuration with pattern initial contents.
module tb_parallel_simple_dual_port_memory;

    logic        clk;
    logic        reset;
    logic [7:0]  addressA;
    logic [1:0]  weA;
    logic [23:0] data_inA;
    logic [7:0]  addressB;
    logic [23:0] data_outB;

    int checks;
    int failures;

    parallel_simple_dual_port_memory #(
        .purpose(1),
        .z      (2),
        .depth  (16),
        .width  (12)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addressA (addressA),
        .weA      (weA),
        .data_inA (data_inA),
        .addressB (addressB),
        .data_outB(data_outB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("check %-14s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pair(input string tag, input logic [11:0] exp0, input logic [11:0] exp1);
        check({tag, "_b0"}, data_outB[11:0], exp0);
        check({tag, "_b1"}, data_outB[23:12], exp1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        weA      = 2'b00;
        addressA = 8'h00;
        data_inA = 24'h000000;
        addressB = {4'd6, 4'd5};

        // Reset held low across several edges.
        repeat (3) step();
        check_pair("rst_hold", 12'h000, 12'h000);

        // Release and read the initial pattern.
        reset = 1'b1;
        step();
        check_pair("init_5_6", 12'hFFA, 12'hFE9);

        // Write both banks; the read address is unrelated so outputs stay.
        weA      = 2'b11;
        addressA = {4'd1, 4'd0};
        data_inA = {12'h006, 12'h005};
        step();
        check_pair("wr_both", 12'hFFA, 12'hFE9);

        weA      = 2'b00;
        addressB = {4'd1, 4'd0};
        step();
        check_pair("rd_written", 12'h005, 12'h006);

        // Collision: bank 1 writes the address it reads, bank 0 is not enabled.
        weA      = 2'b10;
        addressA = {4'd1, 4'd0};
        addressB = {4'd1, 4'd0};
        data_inA = {12'h064, 12'h063};
        step();
        check_pair("rd_first_old", 12'h005, 12'h006);

        weA = 2'b00;
        step();
        check_pair("rd_first_new", 12'h005, 12'h064);

        // Top address of bank 0.
        addressB = {4'd1, 4'hF};
        step();
        check_pair("addr_top", 12'hFF0, 12'h064);

        // Other untouched words, including the top of bank 1.
        addressB = {4'hF, 4'd2};
        step();
        check_pair("init_2_F", 12'hFFD, 12'hFE0);

        // Asynchronous reset between edges clears outputs without a clock edge.
        #3;
        reset = 1'b0;
        #1;
        check_pair("rst_async", 12'h000, 12'h000);

        // Writes attempted during reset must be blocked.
        weA      = 2'b11;
        addressA = {4'd1, 4'd0};
        data_inA = {12'hBBB, 12'hAAA};
        addressB = {4'd1, 4'd0};
        step();
        check_pair("rst_wr_block", 12'h000, 12'h000);

        weA   = 2'b00;
        reset = 1'b1;
        step();
        check_pair("after_rst", 12'h005, 12'h064);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parallel_simple_dual_port_memory.md
# parallel_simple_dual_port_memory

Bank of `z` independent simple dual-port RAMs sharing one clock. Each RAM has a write-only port A and a registered read-only port B, both with per-bank addresses. The block sits between a DNN datapath's producer and consumer stages, which move `z` words per cycle (one per bank). A write enable per bank allows partial-bank updates.

## Interface
Parameters:
- `purpose`, 1: initialisation tag. 0 means contents start at zero; any nonzero value selects the pattern init.
- `z`, 2: number of banks.
- `depth`, 16: words per bank.
- `width`, 12: bits per word.
- `addrsize`, derived local parameter: 1 if `depth==1`, else clog2(`depth`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addressA`  in  [z] × addrsize  port-A write address per bank.
- `weA`  in  z  per-bank write enable; bit i controls bank i.
- `data_inA`  in  [z] × width  port-A write data per bank.
- `addressB`  in  [z] × addrsize  port-B read address per bank.
- `data_outB`  out  [z] × width  registered port-B read data per bank.

## Operation
- Each bank i is an array of `depth` words of `width` bits, fully independent of the other banks.
- Write: on a rising edge with `reset` high and `weA[i]`=1, bank i stores `data_inA[i]` at `addressA[i]`. When `weA[i]`=0, bank i is unchanged.
- Read: on every rising edge with `reset` high, `data_outB[i]` is loaded with bank i's word at `addressB[i]`.
- Read-first: if port B reads the same address port A writes in the same edge, `data_outB[i]` gets the old word. The new word is visible from the next edge onward.
- Initial contents (simulation and FPGA init):
  - `purpose`==0: all words are 0.
  - `purpose`≠0: bank i, address a holds the bitwise inverse of (i·depth + a), truncated to `width` bits.
- Reset clears only `data_outB` and never touches array contents. Arrays are not resettable, which keeps them inferable as block RAM.
- Addresses ≥ `depth` (only possible when `depth` is not a power of 2): reads return 0 and writes are ignored.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and the data is valid after edge N until edge N+1.
- Write latency is 1 cycle: a word written at edge N is readable by an address presented for edge N+1.
- Reset:
  - `reset` low forces all `data_outB` to 0 immediately, with no clock needed.
  - While low, writes are blocked and outputs hold 0.
  - On release, normal operation resumes at the next edge.
  - Asserting reset mid-operation loses only the output registers; stored words remain.
- No handshake. Every bank accepts one write and one read per cycle, unconditionally.

## Structure
- Shared package (`dnn_pkg`) holds no block-specific typedefs. `addrsize` is derived locally using the codebase's standard clog2-with-floor-1 function from that package.
- One sub-module: `simple_dual_port_mem`, a single bank with `depth`, `width`, `purpose` and bank `index` parameters and a read-first registered output. The top generates `z` instances of it.

## Test plan
Configuration: `purpose`=1, `z`=2, `depth`=16, `width`=12.
1. Hold `reset` low with any `addressB` and clock several edges -> `data_outB` = {0,0}. Assert `reset` low between edges -> outputs go to 0 without an edge.
2. Release reset, `weA`=00, `addressB`={bank0:5, bank1:6}, one edge -> `data_outB` = {FFA, FE9} (init pattern).
3. `weA`=11, `addressA`={0,1}, `data_inA`={005,006}, `addressB` unchanged, one edge -> outputs stay {FFA, FE9}. Then read addresses {0,1} -> {005, 006}.
4. Read-first collision: `weA`=10, `addressA`={0,1}, `addressB`={0,1}, `data_inA`={063,064}.
   - First edge -> {005, 006}: old data, and bank 0 is not written.
   - Second edge -> {005, 064}.
5. `addressB[0]`=F with writes disabled, one edge -> `data_outB[0]` = FF0, `data_outB[1]` unchanged at 064.
6. Assert `reset` low after step 5, then release and read {0,1} -> outputs are 0 during reset, then {005, 064} after release (contents survive reset).
